seq_pattern_tx: RTL

//  Serial pattern transmitter: the stimulus end of the serial bit line fed to the sequence detectors.

---
 rtl/seq_pkg.sv | 18 +
 rtl/seq101_monitor.sv | 56 +++++
 rtl/seq_pattern_tx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter and its "101" reference monitor.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        S0  = 2'd0,
        S1  = 2'd1,
        S10 = 2'd2
    } mon_state_e;

    localparam logic [2:0] PAT_101 = 3'b101;

endpackage

// File: rtl/seq101_monitor.sv
// Mealy overlapping "101" detector on a qualified serial stream, with saturating match counter.
module seq101_monitor
    import seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             bit_in,
    input  logic             bit_vld,
    output logic             y,
    output logic [CNT_W-1:0] cnt
);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        y       = 1'b0;
        if (bit_vld) begin
            unique case (state_q)
                S0:  state_d = (bit_in == PAT_101[2]) ? S1 : S0;
                S1:  state_d = (bit_in == PAT_101[1]) ? S10 : S1;
                S10: begin
                    y       = (bit_in == PAT_101[0]);
                    state_d = y ? S1 : S0;
                end
                default: state_d = S0;
            endcase
        end
        if (y && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (clr) begin
            state_d = S0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: loads a WIDTH-bit word and shifts it out LSB-first rep times.
// Define MATCH_MON_EN to build the overlapping "101" reference monitor on (x, x_valid).
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] load_rep,
    input  logic             bit_en,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic             y_ref,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int             BC_W     = $clog2(WIDTH);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    tx_state_e        state_q;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] sh_q;
    logic [CNT_W-1:0] rep_left_q;
    logic [BC_W-1:0]  bit_cnt_q;
    logic             x_q;
    logic             x_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             load_ready_q;
    logic             last_bit;

    assign last_bit = (bit_cnt_q == LAST_BIT);

    // NOTE: non-blocking assignments throughout, so every branch reads pre-edge register values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            // NOTE: pattern registers are cleared too; a reset mid-transfer must leave no stale word.
            shadow_q     <= '0;
            sh_q         <= '0;
            rep_left_q   <= '0;
            bit_cnt_q    <= '0;
            x_q          <= 1'b0;
            x_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    x_valid_q <= 1'b0;
                    if (load_valid) begin
                        shadow_q     <= load_data;
                        sh_q         <= load_data;
                        rep_left_q   <= (load_rep == '0) ? CNT_W'(1) : load_rep;
                        bit_cnt_q    <= '0;
                        state_q      <= SHIFT;
                        busy_q       <= 1'b1;
                        load_ready_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state_q      <= IDLE;
                        x_q          <= 1'b0;
                        x_valid_q    <= 1'b0;
                        busy_q       <= 1'b0;
                        load_ready_q <= 1'b1;
                    end else if (bit_en) begin
                        x_q       <= sh_q[0];
                        x_valid_q <= 1'b1;
                        if (!last_bit) begin
                            sh_q      <= sh_q >> 1;
                            bit_cnt_q <= bit_cnt_q + BC_W'(1);
                        end else if (rep_left_q != CNT_W'(1)) begin
                            // Reload from the shadow copy so the next repetition starts with no gap.
                            sh_q       <= shadow_q;
                            bit_cnt_q  <= '0;
                            rep_left_q <= rep_left_q - CNT_W'(1);
                        end else begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            bit_cnt_q  <= '0;
                            rep_left_q <= '0;
                        end
                    end else begin
                        x_valid_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    done_q       <= 1'b0;
                    busy_q       <= 1'b0;
                    load_ready_q <= 1'b1;
                    x_q          <= 1'b0;
                    x_valid_q    <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    done_q       <= 1'b0;
                    busy_q       <= 1'b0;
                    load_ready_q <= 1'b1;
                    x_q          <= 1'b0;
                    x_valid_q    <= 1'b0;
                end
            endcase
        end
    end

    assign x          = x_q;
    assign x_valid    = x_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = load_ready_q;

`ifdef MATCH_MON_EN
    logic load_fire;
    assign load_fire = load_valid && load_ready_q;

    seq101_monitor #(
        .CNT_W(CNT_W)
    ) u_mon (
        .clk    (clk),
        .reset  (reset),
        .clr    (load_fire),
        .bit_in (x_q),
        .bit_vld(x_valid_q),
        .y      (y_ref),
        .cnt    (match_cnt)
    );
`else
    assign y_ref     = 1'b0;
    assign match_cnt = '0;
`endif

endmodule
